// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand sequencer: opcode encodings, default widths
// and the sequencer FSM state type.
package alu_pkg;

  localparam int unsigned DefWidth      = 64;
  localparam int unsigned DefShiftWidth = 5;
  localparam int unsigned DefOpWidth    = 4;

  localparam logic [3:0] OpRol = 4'd0;
  localparam logic [3:0] OpRor = 4'd1;
  localparam logic [3:0] OpMax = 4'd2;
  localparam logic [3:0] OpMin = 4'd3;
  localparam logic [3:0] OpOr  = 4'd4;
  localparam logic [3:0] OpDiv = 4'd5;
  localparam logic [3:0] OpSub = 4'd6;
  localparam logic [3:0] OpXor = 4'd7;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } seq_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so full and empty
// are distinguished without a separate counter.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]   wptr_q, rptr_q;
  logic [DW-1:0] mem_q [DEPTH];
  logic          push_ok, pop_ok;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + (AW + 1)'(1);
      if (pop_ok)  rptr_q <= rptr_q + (AW + 1)'(1);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Drives queued commands onto an external ALU, waits ALU_LAT extra cycles, captures
// result and flags, and returns them in order on a valid/ready response stream.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned SHW     = DefShiftWidth,
  parameter int unsigned OPW     = DefOpWidth,
  parameter int unsigned TAGW    = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ALU_LAT = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [OPW-1:0]   cmd_opcode_i,
  input  logic [WIDTH-1:0] cmd_a_i,
  input  logic [WIDTH-1:0] cmd_b_i,
  input  logic [SHW-1:0]   cmd_shift_i,
  input  logic [TAGW-1:0]  cmd_tag_i,
  output logic [OPW-1:0]   alu_opcode_o,
  output logic [WIDTH-1:0] alu_input1_o,
  output logic [WIDTH-1:0] alu_input2_o,
  output logic [SHW-1:0]   alu_shift_o,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic             alu_carry_i,
  input  logic             alu_zero_i,
  input  logic             alu_sign_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_result_o,
  output logic             rsp_carry_o,
  output logic             rsp_zero_o,
  output logic             rsp_sign_o,
  output logic             rsp_div0_o,
  output logic [TAGW-1:0]  rsp_tag_o,
  output logic             busy_o
);

  localparam int unsigned CmdW = OPW + 2 * WIDTH + SHW + TAGW;

  logic            fifo_full, fifo_empty, fifo_pop, cmd_push, load;
  logic [CmdW-1:0] fifo_wdata, fifo_rdata;
  logic [OPW-1:0]   f_opcode;
  logic [WIDTH-1:0] f_a, f_b;
  logic [SHW-1:0]   f_shift;
  logic [TAGW-1:0]  f_tag;

  seq_state_e       state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [OPW-1:0]   alu_opcode_q, alu_opcode_d;
  logic [WIDTH-1:0] alu_input1_q, alu_input1_d, alu_input2_q, alu_input2_d;
  logic [SHW-1:0]   alu_shift_q, alu_shift_d;
  logic [TAGW-1:0]  tag_q, tag_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_carry_q, rsp_carry_d, rsp_zero_q, rsp_zero_d;
  logic             rsp_sign_q, rsp_sign_d, rsp_div0_q, rsp_div0_d;
  logic [TAGW-1:0]  rsp_tag_q, rsp_tag_d;

  assign cmd_push   = cmd_valid_i && !fifo_full;
  assign fifo_wdata = {cmd_opcode_i, cmd_a_i, cmd_b_i, cmd_shift_i, cmd_tag_i};
  assign {f_opcode, f_a, f_b, f_shift, f_tag} = fifo_rdata;

  alu_cmd_fifo #(
    .DW    (CmdW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (cmd_push),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_opcode_d = alu_opcode_q;
    alu_input1_d = alu_input1_q;
    alu_input2_d = alu_input2_q;
    alu_shift_d  = alu_shift_q;
    tag_d        = tag_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_sign_d   = rsp_sign_q;
    rsp_div0_d   = rsp_div0_q;
    rsp_tag_d    = rsp_tag_q;
    load         = 1'b0;
    fifo_pop     = 1'b0;

    case (state_q)
      StIdle: begin
        if (!fifo_empty) load = 1'b1;
      end
      StWait: begin
        if (cnt_q == 3'd0) begin
          rsp_valid_d  = 1'b1;
          rsp_result_d = alu_result_i;
          rsp_carry_d  = alu_carry_i;
          rsp_zero_d   = alu_zero_i;
          rsp_sign_d   = alu_sign_i;
          rsp_div0_d   = (alu_opcode_q == OPW'(OpDiv)) && (alu_input2_q == '0);
          rsp_tag_d    = tag_q;
          state_d      = StResp;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StResp: begin
        // Back-to-back: the next command is loaded on the same edge as the handshake.
        if (rsp_ready_i) begin
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            rsp_valid_d = 1'b0;
            state_d     = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      fifo_pop     = 1'b1;
      alu_opcode_d = f_opcode;
      alu_input1_d = f_a;
      alu_input2_d = f_b;
      alu_shift_d  = f_shift;
      tag_d        = f_tag;
      rsp_valid_d  = 1'b0;
      cnt_d        = 3'(ALU_LAT);
      state_d      = StWait;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      alu_opcode_q <= '0;
      alu_input1_q <= '0;
      alu_input2_q <= '0;
      alu_shift_q  <= '0;
      tag_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_sign_q   <= 1'b0;
      rsp_div0_q   <= 1'b0;
      rsp_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_opcode_q <= alu_opcode_d;
      alu_input1_q <= alu_input1_d;
      alu_input2_q <= alu_input2_d;
      alu_shift_q  <= alu_shift_d;
      tag_q        <= tag_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_sign_q   <= rsp_sign_d;
      rsp_div0_q   <= rsp_div0_d;
      rsp_tag_q    <= rsp_tag_d;
    end
  end

  assign cmd_ready_o  = !fifo_full;
  assign busy_o       = !fifo_empty || (state_q != StIdle);
  assign alu_opcode_o = alu_opcode_q;
  assign alu_input1_o = alu_input1_q;
  assign alu_input2_o = alu_input2_q;
  assign alu_shift_o  = alu_shift_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_carry_o  = rsp_carry_q;
  assign rsp_zero_o   = rsp_zero_q;
  assign rsp_sign_o   = rsp_sign_q;
  assign rsp_div0_o   = rsp_div0_q;
  assign rsp_tag_o    = rsp_tag_q;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Initiator side of the generated-ALU operand interface. It accepts tagged ALU commands over a valid/ready stream and buffers them in a small FIFO. It drives opcode, operands and shift onto an external ALU instance, samples result and flags after a fixed latency, and returns them in order on a valid/ready response stream. It lets sequential datapaths and testbenches drive any generated ALU variant, whether combinational or registered.

Parameters:
WIDTH, 64, operand/result width
SHW, 5, shiftValue width
OPW, 4, opcode width
TAGW, 4, command tag width
DEPTH, 4, command FIFO entries (power of 2, >=2)
ALU_LAT, 0, extra cycles the ALU needs before outputs are valid (0..7)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_opcode  in  OPW  ALU opcode
cmd_a  in  WIDTH  operand 1
cmd_b  in  WIDTH  operand 2
cmd_shift  in  SHW  shift amount
cmd_tag  in  TAGW  user tag, returned with response
alu_opcode  out  OPW  to ALU opcode
alu_input1  out  WIDTH  to ALU input1
alu_input2  out  WIDTH  to ALU input2
alu_shift  out  SHW  to ALU shiftValue
alu_result  in  WIDTH  from ALU result
alu_carry  in  1  from ALU carryFlag
alu_zero  in  1  from ALU zeroFlag
alu_sign  in  1  from ALU signFlag
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when valid&ready
rsp_result  out  WIDTH  captured result
rsp_carry  out  1  captured carry
rsp_zero  out  1  captured zero
rsp_sign  out  1  captured sign
rsp_div0  out  1  command was DIV (5) with operand 2 == 0
rsp_tag  out  TAGW  tag of the command
busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, FSM=IDLE, every output register 0; cmd_ready=1 once rst_n is high.
- cmd_ready = !fifo_full. There is no push bypass when full, even if a pop occurs in the same cycle.
- FSM states are IDLE, WAIT and RESP.
- IDLE: if the FIFO is non-empty, pop at the next edge and load alu_* registers and the tag/div0 shadow. Go to WAIT with cnt=ALU_LAT.
- WAIT: alu_* held stable. If cnt==0, capture alu_result/carry/zero/sign into rsp_* at the edge, set rsp_valid=1 and go to RESP. Otherwise decrement cnt.
- RESP: rsp_* held stable while rsp_valid && !rsp_ready. On handshake, if the FIFO is non-empty, pop and load the next command at the same edge, then go to WAIT (back-to-back). If the FIFO is empty, clear rsp_valid and go to IDLE.
- Latency: command accepted into an empty FIFO at edge t gives rsp_valid high from edge t+2+ALU_LAT.
- Sustained throughput: one response per ALU_LAT+2 cycles with rsp_ready held high.
- alu_* outputs keep their last value in IDLE; they return to 0 only on reset.
- rsp_div0 is computed from registered operands: (opcode==5)&&(b==0). ALU flags are forwarded unmodified.
- Opcodes 8..15 are passed to the ALU untouched; the sequencer does no opcode checking.
- Responses are returned strictly in command order. Tags are opaque.
- FIFO pointers are log2(DEPTH)+1 bits and wrap naturally. A simultaneous push and pop on a non-full, non-empty FIFO keeps the count unchanged.
- Reset mid-operation (any state) drops all queued and in-flight commands. rsp_valid falls immediately and asynchronously.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants: ROL=0, ROR=1, MAX=2, MIN=3, OR=4, DIV=5, SUB=6, XOR=7;
  - default width constants (64, 5, 4);
  - the FSM state enum.
- Sub-module alu_cmd_fifo: synchronous FIFO holding {opcode, a, b, shift, tag}, with full/empty outputs and the same clk/rst_n.
- The ALU itself stays external to this block.

Test Plan:
1. Reset with cmd_valid=0 -> all rsp_*/alu_* = 0, rsp_valid=0, busy=0, cmd_ready=1.
2. ALU_LAT=0, combinational ALU model; SUB a=10 b=3 tag=5 accepted at edge t -> rsp_valid at t+2, rsp_result=7, zero=0, sign=0, tag=5.
3. DIV a=100 b=0 -> rsp_result=0, rsp_zero=1, rsp_div0=1; then DIV 100/7 -> result 14, rsp_div0=0.
4. rsp_ready=0, push 5 commands (XOR, OR, MAX, MIN, ROL) -> 4 accepted plus 1 in flight, then cmd_ready=0. Raise rsp_ready -> responses in order, one per 2 cycles. Results include ROL 0x1 by 4 = 0x10 and MAX(3, 9) = 9.
5. ALU_LAT=2 registered ALU model; stall rsp_ready for 5 cycles -> rsp_* and alu_* stable throughout; rsp_valid at t+4.
6. Assert rst_n low during WAIT with 3 queued commands -> outputs clear without a clock edge; after release no responses emerge and busy=0.
